// File: rtl/tick_ctrl.sv
// Tick pacing stage for the HEX digit counters: switch-selected period,
// debounced run/pause and single-step keys, registered TICK/RUNNING.

module tick_ctrl_debounce #(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      s1      <= pin;
      s2      <= s1;
      level_d <= level;
      press   <= level_d & ~level;
      if (s2 != level) begin
        if (cnt == LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module tick_ctrl #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEB_CYCLES   = 500_000,
  parameter bit          RUN_AT_RESET = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] V_RATE,
  input  logic       V_KEY_RUN,
  input  logic       V_KEY_STEP,
  output logic       TICK,
  output logic       RUNNING
);

  localparam logic [31:0] P_HALF = 32'(CLK_HZ / 2);
  localparam logic [31:0] P_ONE  = 32'(CLK_HZ);
  localparam logic [31:0] P_TWO  = 32'(64'(CLK_HZ) * 2);
  localparam logic [31:0] P_SIX  = 32'(64'(CLK_HZ) * 6);

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] div_q;
  logic [31:0] div_d;
  logic        tick_q;
  logic        tick_d;
  logic [1:0]  rate_s1;
  logic [1:0]  rate_s2;
  logic [1:0]  rate_prev;
  logic [31:0] period;
  logic        rate_chg;
  logic        run_ev;
  logic        step_ev;

  tick_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .pin   (V_KEY_RUN),
    .press (run_ev)
  );

  tick_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .pin   (V_KEY_STEP),
    .press (step_ev)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rate_s1   <= 2'd0;
      rate_s2   <= 2'd0;
      rate_prev <= 2'd0;
    end else begin
      rate_s1   <= V_RATE;
      rate_s2   <= rate_s1;
      rate_prev <= rate_s2;
    end
  end

  assign rate_chg = (rate_s2 != rate_prev);

  always_comb begin
    period = P_HALF;
    unique case (rate_s2)
      2'd0: period = P_HALF;
      2'd1: period = P_ONE;
      2'd2: period = P_TWO;
      2'd3: period = P_SIX;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= RUN_AT_RESET ? S_RUN : S_PAUSE;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  // A wrap in the same cycle as a pause still ticks; steps never
  // land directly behind another tick.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    if (rate_chg) begin
      div_d = '0;
    end else if (state_q == S_RUN) begin
      if (div_q == period - 32'd1) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 32'd1;
      end
    end
    unique case (state_q)
      S_PAUSE: begin
        if (run_ev) begin
          state_d = S_RUN;
        end else if (step_ev && !tick_q) begin
          tick_d = 1'b1;
        end
      end
      S_RUN: begin
        if (run_ev) begin
          state_d = S_PAUSE;
        end
      end
    endcase
  end

  assign TICK    = tick_q;
  assign RUNNING = (state_q == S_RUN);

endmodule
